// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute and drives datapath
// selects and state-qualified strobes from the registered state, countdown and error flag.
module mips_ctrl_fsm #(
  parameter int unsigned MULDIV_CYCLES       = 32,
  parameter bit          STALL_EXEC2_ON_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       waitrequest,
  input  logic [5:0] opcode,
  input  logic [5:0] fun,
  input  logic       pc_next_zero,
  output logic [2:0] state,
  output logic       active,
  output logic       error,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       jump,
  output logic       branch,
  output logic       branch_ne,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pctoadd,
  output logic       regtojump,
  output logic       link,
  output logic       memread,
  output logic       memwrite,
  output logic       regwrite,
  output logic       inwrite,
  output logic       pcwrite,
  output logic       hilowrite
);

  localparam int unsigned CNT_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4,
    S_EXEC3  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               error_q, error_d;

  logic is_rtype, is_arith, is_mfhilo, is_muldiv, is_jr, is_jalr;
  logic is_lw, is_sw, is_beq, is_bne, is_addiu, is_j, is_jal;
  logic legal, wr_reg, exec2_leave;

  // Instruction decode from opcode/fun
  always_comb begin
    is_rtype  = (opcode == OP_RTYPE);
    is_arith  = is_rtype && (fun inside {6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                         6'b100110, 6'b101010, 6'b101011});
    is_mfhilo = is_rtype && ((fun == FN_MFHI) || (fun == FN_MFLO));
    is_muldiv = is_rtype && (fun[5:2] == 4'b0110);
    is_jr     = is_rtype && (fun == FN_JR);
    is_jalr   = is_rtype && (fun == FN_JALR);
    is_lw     = (opcode == OP_LW);
    is_sw     = (opcode == OP_SW);
    is_beq    = (opcode == OP_BEQ);
    is_bne    = (opcode == OP_BNE);
    is_addiu  = (opcode == OP_ADDIU);
    is_j      = (opcode == OP_J);
    is_jal    = (opcode == OP_JAL);
    legal     = is_arith || is_mfhilo || is_muldiv || is_jr || is_jalr || is_lw || is_sw ||
                is_beq || is_bne || is_addiu || is_j || is_jal;
    wr_reg    = is_arith || is_mfhilo || is_lw || is_addiu || is_jal || is_jalr;
  end

  // Next state, countdown, error and all outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    exec2_leave = 1'b0;
    ALUOp       = 2'b00;
    ALUSrc      = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    pctoadd     = 1'b0;
    regtojump   = 1'b0;
    link        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    regwrite    = 1'b0;
    inwrite     = 1'b0;
    pcwrite     = 1'b0;
    hilowrite   = 1'b0;

    // Datapath selects are only meaningful once a legal instruction is executing
    if ((state_q == S_EXEC1 || state_q == S_EXEC2 || state_q == S_EXEC3) && legal) begin
      if (is_rtype) begin
        regdst = 1'b1;
        ALUOp  = 2'b10;
      end
      if (is_beq || is_bne) begin
        branch = 1'b1;
        ALUOp  = 2'b01;
      end
      branch_ne = is_bne;
      ALUSrc    = is_lw || is_sw || is_addiu;
      memtoreg  = is_lw;
      jump      = is_j || is_jal || is_jr || is_jalr;
      regtojump = is_jr || is_jalr;
      link      = is_jal || is_jalr;
    end

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        pctoadd = 1'b1;
        if (!waitrequest) state_d = S_DECODE;
      end
      S_DECODE: begin
        inwrite = 1'b1;
        pctoadd = 1'b1;
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (!legal) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end else if (is_lw) begin
          memread = 1'b1;
          if (!waitrequest) state_d = S_EXEC2;
        end else if (is_muldiv) begin
          cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
          state_d = S_EXEC3;
        end else begin
          state_d = S_EXEC2;
        end
      end
      S_EXEC3: begin
        if (cnt_q == '0) state_d = S_EXEC2;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_EXEC2: begin
        memwrite    = is_sw;
        exec2_leave = !(is_sw && waitrequest && STALL_EXEC2_ON_WAIT);
        if (exec2_leave) begin
          pcwrite   = 1'b1;
          regwrite  = wr_reg;
          hilowrite = is_muldiv;
          state_d   = pc_next_zero ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Reset suppresses every side-effecting strobe in the cycle it is applied
    if (reset) begin
      memread   = 1'b0;
      memwrite  = 1'b0;
      regwrite  = 1'b0;
      inwrite   = 1'b0;
      pcwrite   = 1'b0;
      hilowrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign state  = 3'(state_q);
  assign active = (state_q != S_HALT);
  assign error  = error_q;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Scoreboard bench for mips_ctrl_fsm: per-cycle expectations are queued as stimulus is
// driven and compared against DUT outputs on the falling edge.
module tb_mips_ctrl_fsm;

  localparam logic [2:0] ST_HALT = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC1 = 3'd3, ST_EXEC2 = 3'd4, ST_EXEC3 = 3'd5, ST_NONE = 3'd7;

  // strobe order {memread, memwrite, regwrite, inwrite, pcwrite, hilowrite}
  localparam logic [5:0] SB_0     = 6'b000000;
  localparam logic [5:0] SB_FETCH = 6'b100000;
  localparam logic [5:0] SB_DEC   = 6'b000100;
  localparam logic [5:0] SB_RW_PW = 6'b001010;
  localparam logic [5:0] SB_HL_PW = 6'b000011;
  localparam logic [5:0] SB_PW    = 6'b000010;
  localparam logic [5:0] SB_MW    = 6'b010000;
  localparam logic [5:0] SB_MW_PW = 6'b010010;

  // select order {ALUOp[1:0], ALUSrc, jump, branch, branch_ne, regdst, memtoreg, pctoadd, regtojump, link}
  localparam logic [10:0] SEL_PC = 11'b00_0_0_0_0_0_0_1_0_0;
  localparam logic [10:0] SEL_R  = 11'b10_0_0_0_0_1_0_0_0_0;
  localparam logic [10:0] SEL_LW = 11'b00_1_0_0_0_0_1_0_0_0;
  localparam logic [10:0] SEL_SW = 11'b00_1_0_0_0_0_0_0_0_0;
  localparam logic [10:0] SEL_JR = 11'b10_0_1_0_0_1_0_0_1_0;
  localparam logic [10:0] M_ALL  = 11'h7FF;
  localparam logic [10:0] M_PC   = 11'h004;
  localparam logic [10:0] M_NONE = 11'h000;

  logic       clk, reset, waitrequest, pc_next_zero;
  logic [5:0] opcode, fun;

  logic [2:0] state, state_b;
  logic       active, error, active_b, error_b;
  logic [1:0] ALUOp, ALUOp_b;
  logic       ALUSrc, jump, branch, branch_ne, regdst, memtoreg, pctoadd, regtojump, link;
  logic       memread, memwrite, regwrite, inwrite, pcwrite, hilowrite;
  logic       ALUSrc_b, jump_b, branch_b, branch_ne_b, regdst_b, memtoreg_b, pctoadd_b;
  logic       regtojump_b, link_b, memread_b, memwrite_b, regwrite_b, inwrite_b, pcwrite_b;
  logic       hilowrite_b;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [5:0]  strb;
    logic        err;
    logic [10:0] sel;
    logic [10:0] msk;
    logic [2:0]  st2;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic exp_err;
  int   n_run, n_fail;

  mips_ctrl_fsm #(.MULDIV_CYCLES(4), .STALL_EXEC2_ON_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .opcode(opcode), .fun(fun),
    .pc_next_zero(pc_next_zero), .state(state), .active(active), .error(error),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .jump(jump), .branch(branch), .branch_ne(branch_ne),
    .regdst(regdst), .memtoreg(memtoreg), .pctoadd(pctoadd), .regtojump(regtojump),
    .link(link), .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
    .inwrite(inwrite), .pcwrite(pcwrite), .hilowrite(hilowrite)
  );

  mips_ctrl_fsm #(.MULDIV_CYCLES(4), .STALL_EXEC2_ON_WAIT(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .opcode(opcode), .fun(fun),
    .pc_next_zero(pc_next_zero), .state(state_b), .active(active_b), .error(error_b),
    .ALUOp(ALUOp_b), .ALUSrc(ALUSrc_b), .jump(jump_b), .branch(branch_b),
    .branch_ne(branch_ne_b), .regdst(regdst_b), .memtoreg(memtoreg_b), .pctoadd(pctoadd_b),
    .regtojump(regtojump_b), .link(link_b), .memread(memread_b), .memwrite(memwrite_b),
    .regwrite(regwrite_b), .inwrite(inwrite_b), .pcwrite(pcwrite_b), .hilowrite(hilowrite_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic wr, input logic pnz, input logic [2:0] st,
                     input logic [5:0] strb, input logic [10:0] sel, input logic [10:0] msk,
                     input logic [2:0] st2);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    waitrequest  = wr;
    pc_next_zero = pnz;
    e.tag = tag; e.st = st; e.strb = strb; e.err = exp_err;
    e.sel = sel; e.msk = msk; e.st2 = st2;
    sb_q.push_back(e);
  endtask

  // Two reset cycles with waitrequest high; the second one is checked for FETCH, no strobes
  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    reset       = 1'b1;
    waitrequest = 1'b1;
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    e.tag = "reset"; e.st = ST_FETCH; e.strb = SB_0; e.err = 1'b0;
    e.sel = '0; e.msk = M_NONE; e.st2 = ST_FETCH;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_eq({mon_e.tag, ".state"}, 32'(state), 32'(mon_e.st));
      check_eq({mon_e.tag, ".strobes"},
               32'({memread, memwrite, regwrite, inwrite, pcwrite, hilowrite}), 32'(mon_e.strb));
      check_eq({mon_e.tag, ".active"}, 32'(active), 32'(mon_e.st != ST_HALT));
      check_eq({mon_e.tag, ".error"}, 32'(error), 32'(mon_e.err));
      if (mon_e.msk != M_NONE)
        check_eq({mon_e.tag, ".sel"},
                 32'({ALUOp, ALUSrc, jump, branch, branch_ne, regdst, memtoreg, pctoadd,
                      regtojump, link} & mon_e.msk), 32'(mon_e.sel & mon_e.msk));
      if (mon_e.st2 != ST_NONE)
        check_eq({mon_e.tag, ".nostall_state"}, 32'(state_b), 32'(mon_e.st2));
    end
  end

  initial begin
    n_run = 0; n_fail = 0; exp_err = 1'b0;
    reset = 1'b1; waitrequest = 1'b0; pc_next_zero = 1'b0;
    opcode = 6'b0; fun = 6'b0;

    // addu, no waits
    do_reset();
    opcode = 6'b000000; fun = 6'b100001;
    cyc("addu.f",  0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_NONE);
    cyc("addu.d",  0, 0, ST_DECODE, SB_DEC,   SEL_PC, M_PC,  ST_NONE);
    cyc("addu.e1", 0, 0, ST_EXEC1,  SB_0,     SEL_R,  M_ALL, ST_NONE);
    cyc("addu.e2", 0, 0, ST_EXEC2,  SB_RW_PW, SEL_R,  M_ALL, ST_NONE);
    cyc("addu.f2", 0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_NONE);

    // lw with fetch and memory-read stalls
    do_reset();
    opcode = 6'b100011; fun = 6'b000000;
    for (int i = 0; i < 3; i++) cyc("lw.fwait", 1, 0, ST_FETCH, SB_FETCH, SEL_PC, M_PC, ST_NONE);
    cyc("lw.f", 0, 0, ST_FETCH, SB_FETCH, SEL_PC, M_PC, ST_NONE);
    cyc("lw.d", 0, 0, ST_DECODE, SB_DEC, SEL_PC, M_PC, ST_NONE);
    for (int i = 0; i < 2; i++) cyc("lw.e1wait", 1, 0, ST_EXEC1, SB_FETCH, SEL_LW, M_ALL, ST_NONE);
    cyc("lw.e1", 0, 0, ST_EXEC1, SB_FETCH, SEL_LW, M_ALL, ST_NONE);
    cyc("lw.e2", 0, 0, ST_EXEC2, SB_RW_PW, SEL_LW, M_ALL, ST_NONE);
    cyc("lw.f2", 0, 0, ST_FETCH, SB_FETCH, SEL_PC, M_PC, ST_NONE);

    // mult: four EXEC3 cycles, waitrequest ignored there
    do_reset();
    opcode = 6'b000000; fun = 6'b011000;
    cyc("mult.f",  0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_NONE);
    cyc("mult.d",  0, 0, ST_DECODE, SB_DEC,   SEL_PC, M_PC,  ST_NONE);
    cyc("mult.e1", 0, 0, ST_EXEC1,  SB_0,     SEL_R,  M_ALL, ST_NONE);
    for (int i = 0; i < 4; i++) cyc("mult.e3", 1, 0, ST_EXEC3, SB_0, SEL_R, M_ALL, ST_NONE);
    cyc("mult.e2", 0, 0, ST_EXEC2,  SB_HL_PW, SEL_R,  M_ALL, ST_NONE);
    cyc("mult.f2", 0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_NONE);

    // jr to address 0 halts and stays halted
    do_reset();
    opcode = 6'b000000; fun = 6'b001000;
    cyc("jr.f",  0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_NONE);
    cyc("jr.d",  0, 0, ST_DECODE, SB_DEC,   SEL_PC, M_PC,  ST_NONE);
    cyc("jr.e1", 0, 0, ST_EXEC1,  SB_0,     SEL_JR, M_ALL, ST_NONE);
    cyc("jr.e2", 0, 1, ST_EXEC2,  SB_PW,    SEL_JR, M_ALL, ST_NONE);
    for (int i = 0; i < 10; i++)
      cyc("jr.halt", 1'($urandom_range(0, 1)), 0, ST_HALT, SB_0, '0, M_NONE, ST_NONE);

    // illegal opcode sets sticky error; reset clears it
    do_reset();
    opcode = 6'b111111; fun = 6'b000000;
    cyc("ill.f",  0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC, ST_NONE);
    cyc("ill.d",  0, 0, ST_DECODE, SB_DEC,   SEL_PC, M_PC, ST_NONE);
    cyc("ill.e1", 0, 0, ST_EXEC1,  SB_0,     '0,     M_NONE, ST_NONE);
    exp_err = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ill.halt", 0, 0, ST_HALT, SB_0, '0, M_NONE, ST_NONE);
    do_reset();
    cyc("ill.f2", 0, 0, ST_FETCH, SB_FETCH, SEL_PC, M_PC, ST_NONE);

    // sw stalled in EXEC2; the non-stalling instance leaves after one cycle
    do_reset();
    opcode = 6'b101011; fun = 6'b000000;
    cyc("sw.f",   0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_FETCH);
    cyc("sw.d",   0, 0, ST_DECODE, SB_DEC,   SEL_PC, M_PC,  ST_DECODE);
    cyc("sw.e1",  0, 0, ST_EXEC1,  SB_0,     SEL_SW, M_ALL, ST_EXEC1);
    cyc("sw.e2a", 1, 0, ST_EXEC2,  SB_MW,    SEL_SW, M_ALL, ST_EXEC2);
    cyc("sw.e2b", 1, 0, ST_EXEC2,  SB_MW,    SEL_SW, M_ALL, ST_FETCH);
    cyc("sw.e2c", 0, 0, ST_EXEC2,  SB_MW_PW, SEL_SW, M_ALL, ST_FETCH);
    cyc("sw.f2",  0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_DECODE);

    // reset in the middle of EXEC3
    do_reset();
    opcode = 6'b000000; fun = 6'b011010;
    cyc("rst3.f",  0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_NONE);
    cyc("rst3.d",  0, 0, ST_DECODE, SB_DEC,   SEL_PC, M_PC,  ST_NONE);
    cyc("rst3.e1", 0, 0, ST_EXEC1,  SB_0,     SEL_R,  M_ALL, ST_NONE);
    cyc("rst3.e3", 0, 0, ST_EXEC3,  SB_0,     SEL_R,  M_ALL, ST_NONE);
    cyc("rst3.e3", 0, 0, ST_EXEC3,  SB_0,     SEL_R,  M_ALL, ST_NONE);
    do_reset();
    cyc("rst3.f2", 0, 0, ST_FETCH,  SB_FETCH, SEL_PC, M_PC,  ST_NONE);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
